// File: rtl/reg_check_monitor.sv
// Self-check monitor: counts cycles from start, then scans a table of expected
// register values through a register-file read port and reports the outcome.
module reg_check_monitor #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_CHECKS = 8,
    parameter int unsigned CYCLE_W    = 32,
    parameter int unsigned IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tbl_wr,
    input  logic [IDX_W-1:0]   tbl_idx,
    input  logic [ADDR_W-1:0]  tbl_raddr,
    input  logic [DATA_W-1:0]  tbl_exp,
    input  logic [DATA_W-1:0]  tbl_mask,
    input  logic               tbl_clear,
    input  logic               start,
    input  logic [CYCLE_W-1:0] check_cycle,
    output logic [ADDR_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0]  rf_rdata,
    output logic               busy,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               done,
    output logic               pass,
    output logic [IDX_W:0]     fail_count,
    output logic [IDX_W-1:0]   first_fail_idx,
    output logic [DATA_W-1:0]  first_fail_got
);

    localparam int unsigned FC_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] mask;
    } entry_t;

    state_t              state, state_next;
    entry_t              tbl_q [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] valid_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CYCLE_W-1:0]  target_q;

    logic   tbl_open;
    logic   wr_ok;
    logic   hit_target;
    logic   last_idx;
    logic   entry_fail;
    entry_t cur;

    assign tbl_open   = (state == IDLE) || (state == DONE);
    assign wr_ok      = tbl_wr && (32'(tbl_idx) < NUM_CHECKS);
    assign hit_target = (cycle_count == target_q);
    assign last_idx   = (idx_q == IDX_W'(NUM_CHECKS - 1));
    assign cur        = tbl_q[idx_q];
    assign entry_fail = valid_q[idx_q] && (((rf_rdata ^ cur.exp) & cur.mask) != '0);
    assign rf_raddr   = (state == SCAN) ? cur.raddr : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start)      state_next = COUNT;
            COUNT:      if (hit_target) state_next = SCAN;
            SCAN:       if (last_idx)   state_next = DONE;
            default:                    state_next = IDLE;
        endcase
    end

    // Table valid bits; clear takes effect before a same-cycle write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (tbl_open) begin
            if (tbl_clear) valid_q <= '0;
            if (wr_ok)     valid_q[tbl_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_open && wr_ok) tbl_q[tbl_idx] <= '{raddr: tbl_raddr, exp: tbl_exp, mask: tbl_mask};
    end

    // Run datapath: cycle counter, scan index and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q          <= '0;
            target_q       <= '0;
            busy           <= 1'b0;
            cycle_count    <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        target_q       <= (check_cycle == '0) ? CYCLE_W'(1) : check_cycle;
                        cycle_count    <= CYCLE_W'(1);
                        idx_q          <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        first_fail_got <= '0;
                    end
                end
                COUNT: begin
                    if (hit_target) idx_q       <= '0;
                    else            cycle_count <= cycle_count + CYCLE_W'(1);
                end
                SCAN: begin
                    if (entry_fail) begin
                        fail_count <= fail_count + FC_W'(1);
                        if (fail_count == '0) begin
                            first_fail_idx <= idx_q;
                            first_fail_got <= rf_rdata;
                        end
                    end
                    if (last_idx) begin
                        idx_q <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_count == '0) && !entry_fail;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_check_monitor.sv
// Scoreboard bench for reg_check_monitor: runs push expected results, a monitor
// pops and compares them when done rises.
module tb_reg_check_monitor;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned NUM_CHECKS = 8;
    localparam int unsigned CYCLE_W    = 32;
    localparam int unsigned IDX_W      = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               tbl_wr;
    logic [IDX_W-1:0]   tbl_idx;
    logic [ADDR_W-1:0]  tbl_raddr;
    logic [DATA_W-1:0]  tbl_exp;
    logic [DATA_W-1:0]  tbl_mask;
    logic               tbl_clear;
    logic               start;
    logic [CYCLE_W-1:0] check_cycle;
    logic [ADDR_W-1:0]  rf_raddr;
    logic [DATA_W-1:0]  rf_rdata;
    logic               busy;
    logic [CYCLE_W-1:0] cycle_count;
    logic               done;
    logic               pass;
    logic [IDX_W:0]     fail_count;
    logic [IDX_W-1:0]   first_fail_idx;
    logic [DATA_W-1:0]  first_fail_got;

    logic [DATA_W-1:0] regs [32];

    typedef struct {
        logic        pass;
        int          fc;
        int          ffi;
        logic [31:0] ffg;
        int          cyc;
        int          bcyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign rf_rdata = regs[rf_raddr];

    reg_check_monitor #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NUM_CHECKS),
        .CYCLE_W(CYCLE_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .tbl_wr(tbl_wr), .tbl_idx(tbl_idx),
        .tbl_raddr(tbl_raddr), .tbl_exp(tbl_exp), .tbl_mask(tbl_mask),
        .tbl_clear(tbl_clear), .start(start), .check_cycle(check_cycle),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .busy(busy),
        .cycle_count(cycle_count), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx),
        .first_fail_got(first_fail_got)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    // Monitor: measures busy length and checks results when done rises
    logic busy_d = 1'b0;
    logic done_d = 1'b0;
    int   bcyc   = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            if (!busy_d) bcyc = 1;
            else         bcyc++;
        end
        if (done && !done_d) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = q.pop_front();
                chk("pass",           64'(pass),           64'(e.pass));
                chk("fail_count",     64'(fail_count),     64'(e.fc));
                chk("first_fail_idx", 64'(first_fail_idx), 64'(e.ffi));
                chk("first_fail_got", 64'(first_fail_got), 64'(e.ffg));
                chk("cycle_count",    64'(cycle_count),    64'(e.cyc));
                chk("busy_cycles",    64'(bcyc),           64'(e.bcyc));
            end
        end
        busy_d = busy;
        done_d = done;
    end

    task automatic wr(input int idx, input int ra, input logic [31:0] ex, input logic [31:0] mk,
                      input logic clr);
        @(negedge clk);
        tbl_wr    = 1'b1;
        tbl_idx   = IDX_W'(idx);
        tbl_raddr = ADDR_W'(ra);
        tbl_exp   = ex;
        tbl_mask  = mk;
        tbl_clear = clr;
        @(negedge clk);
        tbl_wr    = 1'b0;
        tbl_clear = 1'b0;
    endtask

    task automatic expect_run(input logic p, input int fc, input int ffi, input logic [31:0] ffg,
                              input int cc);
        exp_t e;
        e.pass = p; e.fc = fc; e.ffi = ffi; e.ffg = ffg;
        e.cyc  = (cc == 0) ? 1 : cc;
        e.bcyc = e.cyc + NUM_CHECKS;
        q.push_back(e);
    endtask

    // Returns at the negedge after the start-sampling edge
    task automatic pulse_start(input int cc);
        @(negedge clk);
        check_cycle = CYCLE_W'(cc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 500; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("done_seen", 64'(done), 64'(1));
        @(negedge clk);
    endtask

    task automatic run(input int cc);
        pulse_start(cc);
        wait_done();
    endtask

    initial begin
        rst = 1'b1; tbl_wr = 1'b0; tbl_idx = '0; tbl_raddr = '0; tbl_exp = '0;
        tbl_mask = '0; tbl_clear = 1'b0; start = 1'b0; check_cycle = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hDEAD0000 + 32'(i);
        repeat (3) @(negedge clk);
        chk("rst_busy",   64'(busy),           64'(0));
        chk("rst_done",   64'(done),           64'(0));
        chk("rst_pass",   64'(pass),           64'(0));
        chk("rst_cycle",  64'(cycle_count),    64'(0));
        chk("rst_fc",     64'(fail_count),     64'(0));
        chk("rst_ffi",    64'(first_fail_idx), 64'(0));
        chk("rst_ffg",    64'(first_fail_got), 64'(0));
        chk("rst_raddr",  64'(rf_raddr),       64'(0));
        rst = 1'b0;

        // All five entries match
        regs[19] = 15; regs[20] = 20; regs[21] = 21; regs[22] = 22; regs[23] = 43;
        wr(0, 19, 15, 32'hFFFFFFFF, 1'b0);
        wr(1, 20, 20, 32'hFFFFFFFF, 1'b0);
        wr(2, 21, 21, 32'hFFFFFFFF, 1'b0);
        wr(3, 22, 22, 32'hFFFFFFFF, 1'b0);
        wr(4, 23, 43, 32'hFFFFFFFF, 1'b0);
        expect_run(1'b1, 0, 0, 32'h0, 9);
        run(9);

        // Entry 4 mismatches
        regs[23] = 42;
        expect_run(1'b0, 1, 4, 32'd42, 9);
        run(9);

        // Masked compare: low nibble matches, high nibble differs
        regs[5] = 32'h1234567F;
        wr(0, 5, 32'h000000FF, 32'h0000000F, 1'b1);
        expect_run(1'b1, 0, 0, 32'h0, 3);
        run(3);
        wr(0, 5, 32'h000000FF, 32'h000000F0, 1'b0);
        expect_run(1'b0, 1, 0, 32'h1234567F, 3);
        run(3);

        // check_cycle=0, table write during COUNT and start during SCAN are ignored
        expect_run(1'b0, 1, 0, 32'h1234567F, 0);
        pulse_start(0);
        tbl_wr = 1'b1; tbl_idx = '0; tbl_raddr = 5'd7; tbl_exp = '0; tbl_mask = '0;
        @(negedge clk);
        tbl_wr = 1'b0;
        chk("scan_raddr_entry0", 64'(rf_raddr), 64'(5));
        chk("scan_busy",         64'(busy),     64'(1));
        check_cycle = 32'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset mid-SCAN after two entries
        pulse_start(2);
        repeat (4) @(negedge clk);
        chk("midscan_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("arst_busy",   64'(busy),           64'(0));
        chk("arst_done",   64'(done),           64'(0));
        chk("arst_pass",   64'(pass),           64'(0));
        chk("arst_cycle",  64'(cycle_count),    64'(0));
        chk("arst_fc",     64'(fail_count),     64'(0));
        chk("arst_ffi",    64'(first_fail_idx), 64'(0));
        chk("arst_ffg",    64'(first_fail_got), 64'(0));
        chk("arst_raddr",  64'(rf_raddr),       64'(0));
        @(negedge clk);
        rst = 1'b0;
        expect_run(1'b1, 0, 0, 32'h0, 4);
        run(4);

        // Clear and write in the same cycle: only entry 3 survives
        regs[1] = 1; regs[2] = 2; regs[3] = 3; regs[10] = 32'hABCE;
        wr(0, 1, 32'h11, 32'hFFFFFFFF, 1'b0);
        wr(1, 2, 32'h22, 32'hFFFFFFFF, 1'b0);
        wr(2, 3, 32'h33, 32'hFFFFFFFF, 1'b0);
        wr(3, 10, 32'hABCD, 32'hFFFFFFFF, 1'b1);
        expect_run(1'b0, 1, 3, 32'hABCE, 5);
        run(5);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
